alu_arbiter_seq: RTL and testbench

- Shares the single 4-bit combinational ALU (ops AND 000, OR 001, ADD 010, SUB 110, PIB 111) between two requesters.
- Round-robin arbitration; operands and op are registered and held on the ALU for EXEC_CYCLES settle cycles.
- Result and zero/carry flags are captured and returned on a per-requester valid/ready response channel.
- Sits between the ALU and the blocks issuing operations; the ALU stays purely combinational.

---
 rtl/alu_arbiter_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_arbiter_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_seq.sv
// Round-robin sequencer that shares one combinational 4-bit ALU between two requesters.
// Operands are held on the ALU for EXEC_CYCLES cycles; result and flags return on a per-requester valid/ready channel.
module alu_arbiter_seq #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_0,
  input  logic       req_valid_1,
  output logic       req_ready_0,
  output logic       req_ready_1,
  input  logic [3:0] req_a_0,
  input  logic [3:0] req_a_1,
  input  logic [3:0] req_b_0,
  input  logic [3:0] req_b_1,
  input  logic [2:0] req_op_0,
  input  logic [2:0] req_op_1,
  output logic       rsp_valid_0,
  output logic       rsp_valid_1,
  input  logic       rsp_ready_0,
  input  logic       rsp_ready_1,
  output logic [3:0] rsp_result_0,
  output logic [3:0] rsp_result_1,
  output logic       rsp_zero_0,
  output logic       rsp_zero_1,
  output logic       rsp_carry_0,
  output logic       rsp_carry_1,
  output logic       rsp_err_0,
  output logic       rsp_err_1,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] result;
    logic       zero;
    logic       carry;
    logic       err;
  } rsp_t;

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic       ptr;
  logic       gid;
  logic [3:0] cnt;
  rsp_t       rsp_q [2];
  logic [1:0] rsp_valid_q;

  logic       in_idle;
  logic       grant_0;
  logic       grant_1;
  logic       accept;
  logic       acc_id;
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic [2:0] sel_op;
  logic       op_legal;
  logic       exec_done;
  logic       rsp_take;

  // Grant logic: a lone requester always wins; a tie goes to the pointer.
  assign in_idle = (state == IDLE);
  assign grant_0 = in_idle & req_valid_0 & (~req_valid_1 | ~ptr);
  assign grant_1 = in_idle & req_valid_1 & (~req_valid_0 |  ptr);
  assign accept  = grant_0 | grant_1;
  assign acc_id  = grant_1;

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  assign sel_a  = acc_id ? req_a_1  : req_a_0;
  assign sel_b  = acc_id ? req_b_1  : req_b_0;
  assign sel_op = acc_id ? req_op_1 : req_op_0;

  always_comb begin
    case (sel_op)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  assign exec_done = (state == EXEC) && (cnt == LAST_CNT);
  assign rsp_take  = (state == RESP) && rsp_valid_q[gid]
                     && (gid ? rsp_ready_1 : rsp_ready_0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: next-state gets its default first so no path leaves it unassigned
  // (an unassigned path would infer a latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = op_legal ? EXEC : RESP;
      EXEC: if (exec_done) state_next = RESP;
      RESP: if (rsp_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU-driving registers, pointer, exec counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= 1'b0;
      gid         <= 1'b0;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      rsp_valid_q <= '0;
      rsp_q[0]    <= '0;
      rsp_q[1]    <= '0;
    end else begin
      if (accept) begin
        alu_a  <= sel_a;
        alu_b  <= sel_b;
        alu_op <= sel_op;
        gid    <= acc_id;
        ptr    <= ~acc_id;
        cnt    <= '0;
        // Illegal ops skip EXEC and answer on the next cycle with an error.
        if (!op_legal) begin
          rsp_q[acc_id]       <= '{result: 4'd0, zero: 1'b0, carry: 1'b0, err: 1'b1};
          rsp_valid_q[acc_id] <= 1'b1;
        end
      end else if ((state == EXEC) && !exec_done) begin
        cnt <= cnt + 4'd1;
      end

      if (exec_done) begin
        rsp_q[gid]       <= '{result: alu_result, zero: alu_zero, carry: alu_carry, err: 1'b0};
        rsp_valid_q[gid] <= 1'b1;
      end

      if (rsp_take) rsp_valid_q[gid] <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

  assign rsp_valid_0  = rsp_valid_q[0];
  assign rsp_valid_1  = rsp_valid_q[1];
  assign rsp_result_0 = rsp_q[0].result;
  assign rsp_result_1 = rsp_q[1].result;
  assign rsp_zero_0   = rsp_q[0].zero;
  assign rsp_zero_1   = rsp_q[1].zero;
  assign rsp_carry_0  = rsp_q[0].carry;
  assign rsp_carry_1  = rsp_q[1].carry;
  assign rsp_err_0    = rsp_q[0].err;
  assign rsp_err_1    = rsp_q[1].err;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Bench for alu_arbiter_seq: transaction-level model with per-cycle compare on the EXEC_CYCLES=1 instance,
// plus directed literal checks on it and on a second EXEC_CYCLES=4 instance.
module tb_alu_arbiter_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Environment ALU: returns {result, zero, carry}; SUB carry is the borrow.
  function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] s;
    case (op)
      3'b000:  s = {1'b0, a & b};
      3'b001:  s = {1'b0, a | b};
      3'b010:  s = {1'b0, a} + {1'b0, b};
      3'b110:  s = {1'b0, a} - {1'b0, b};
      3'b111:  s = {1'b0, b};
      default: s = 5'd0;
    endcase
    return {s[3:0], (s[3:0] == 4'd0), s[4]};
  endfunction

  // ---------------- main instance, EXEC_CYCLES = 1 ----------------
  logic       req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [3:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [2:0] req_op_0, req_op_1;
  logic       rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
  logic [3:0] rsp_result_0, rsp_result_1;
  logic       rsp_zero_0, rsp_zero_1, rsp_carry_0, rsp_carry_1, rsp_err_0, rsp_err_1;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_zero, alu_carry, busy;

  assign {alu_result, alu_zero, alu_carry} = alu_f(alu_a, alu_b, alu_op);

  alu_arbiter_seq #(.EXEC_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1), .req_b_0(req_b_0), .req_b_1(req_b_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_result_0(rsp_result_0), .rsp_result_1(rsp_result_1),
    .rsp_zero_0(rsp_zero_0), .rsp_zero_1(rsp_zero_1),
    .rsp_carry_0(rsp_carry_0), .rsp_carry_1(rsp_carry_1),
    .rsp_err_0(rsp_err_0), .rsp_err_1(rsp_err_1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .busy(busy)
  );

  logic [27:0] all_out;
  assign all_out = {busy, rsp_valid_0, rsp_valid_1, alu_a, alu_b, alu_op,
                    rsp_result_0, rsp_result_1, rsp_zero_0, rsp_zero_1,
                    rsp_carry_0, rsp_carry_1, rsp_err_0, rsp_err_1};

  // ---------------- second instance, EXEC_CYCLES = 4 ----------------
  logic       x_req_valid_0, x_req_valid_1, x_req_ready_0, x_req_ready_1;
  logic [3:0] x_req_a_0, x_req_a_1, x_req_b_0, x_req_b_1;
  logic [2:0] x_req_op_0, x_req_op_1;
  logic       x_rsp_valid_0, x_rsp_valid_1, x_rsp_ready_0, x_rsp_ready_1;
  logic [3:0] x_rsp_result_0, x_rsp_result_1;
  logic       x_rsp_zero_0, x_rsp_zero_1, x_rsp_carry_0, x_rsp_carry_1, x_rsp_err_0, x_rsp_err_1;
  logic [3:0] x_alu_a, x_alu_b, x_alu_result;
  logic [2:0] x_alu_op;
  logic       x_alu_zero, x_alu_carry, x_busy;

  assign {x_alu_result, x_alu_zero, x_alu_carry} = alu_f(x_alu_a, x_alu_b, x_alu_op);

  alu_arbiter_seq #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(x_req_valid_0), .req_valid_1(x_req_valid_1),
    .req_ready_0(x_req_ready_0), .req_ready_1(x_req_ready_1),
    .req_a_0(x_req_a_0), .req_a_1(x_req_a_1), .req_b_0(x_req_b_0), .req_b_1(x_req_b_1),
    .req_op_0(x_req_op_0), .req_op_1(x_req_op_1),
    .rsp_valid_0(x_rsp_valid_0), .rsp_valid_1(x_rsp_valid_1),
    .rsp_ready_0(x_rsp_ready_0), .rsp_ready_1(x_rsp_ready_1),
    .rsp_result_0(x_rsp_result_0), .rsp_result_1(x_rsp_result_1),
    .rsp_zero_0(x_rsp_zero_0), .rsp_zero_1(x_rsp_zero_1),
    .rsp_carry_0(x_rsp_carry_0), .rsp_carry_1(x_rsp_carry_1),
    .rsp_err_0(x_rsp_err_0), .rsp_err_1(x_rsp_err_1),
    .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_op(x_alu_op),
    .alu_result(x_alu_result), .alu_zero(x_alu_zero), .alu_carry(x_alu_carry),
    .busy(x_busy)
  );

  // ---------------- transaction model of the main instance ----------------
  localparam int E_MAIN = 1;
  bit         m_busy, m_id, m_ptr;
  int         m_acc, m_due;
  logic [3:0] m_a, m_b;
  logic [2:0] m_op;
  logic [6:0] m_rsp;  // {result, zero, carry, err}

  always @(negedge clk) begin
    logic g0, g1, ev0, ev1, illegal;
    if (!rst_n) begin
      m_busy = 0; m_ptr = 0; m_id = 0;
      m_a = '0; m_b = '0; m_op = '0;
      check("m_reset_outputs", 32'(all_out), 32'd0);
    end else begin
      g0  = !m_busy && req_valid_0 && (!req_valid_1 || m_ptr == 1'b0);
      g1  = !m_busy && req_valid_1 && (!req_valid_0 || m_ptr == 1'b1);
      ev0 = m_busy && (m_id == 1'b0) && (cyc >= m_due);
      ev1 = m_busy && (m_id == 1'b1) && (cyc >= m_due);
      check("m_req_ready", 32'({req_ready_1, req_ready_0}), 32'({g1, g0}));
      check("m_rsp_valid", 32'({rsp_valid_1, rsp_valid_0}), 32'({ev1, ev0}));
      check("m_busy", 32'(busy), 32'(m_busy && (cyc > m_acc)));
      check("m_alu_regs", 32'({alu_a, alu_b, alu_op}), 32'({m_a, m_b, m_op}));
      if (ev0) check("m_rsp_data_0", 32'({rsp_result_0, rsp_zero_0, rsp_carry_0, rsp_err_0}), 32'(m_rsp));
      if (ev1) check("m_rsp_data_1", 32'({rsp_result_1, rsp_zero_1, rsp_carry_1, rsp_err_1}), 32'(m_rsp));
      if ((ev0 && rsp_ready_0) || (ev1 && rsp_ready_1)) m_busy = 0;
      if (g0 || g1) begin
        m_busy = 1; m_acc = cyc; m_id = g1; m_ptr = !g1;
        m_a  = g1 ? req_a_1  : req_a_0;
        m_b  = g1 ? req_b_1  : req_b_0;
        m_op = g1 ? req_op_1 : req_op_0;
        illegal = (m_op == 3'b011) || (m_op == 3'b100) || (m_op == 3'b101);
        m_rsp = illegal ? 7'b0000_0_0_1 : {alu_f(m_a, m_b, m_op), 1'b0};
        m_due = cyc + (illegal ? 1 : E_MAIN + 1);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int order[3];
    int ngrant;
    bit got0, got1, dropped;
    logic [5:0] r0, r1;

    rst_n = 0;
    {req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1, req_op_0, req_op_1} = '0;
    {x_req_valid_0, x_req_valid_1, x_req_a_0, x_req_a_1, x_req_b_0, x_req_b_1, x_req_op_0, x_req_op_1} = '0;
    rsp_ready_0 = 1; rsp_ready_1 = 1; x_rsp_ready_0 = 1; x_rsp_ready_1 = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("reset_outputs", 32'(all_out), 32'd0);
    check("reset_busy4", 32'({x_busy, x_rsp_valid_0, x_rsp_valid_1, x_alu_a}), 32'd0);

    // Single AND on req0: C & A = 8.
    @(posedge clk); #1;
    req_valid_0 = 1; req_a_0 = 4'hC; req_b_0 = 4'hA; req_op_0 = 3'b000;
    @(negedge clk); check("t1_ready_T", 32'(req_ready_0), 32'd1);
    @(posedge clk); #1; req_valid_0 = 0;
    @(negedge clk); check("t1_T1_busy_valid", 32'({busy, rsp_valid_0}), 32'b10);
    @(negedge clk); check("t1_T2_rsp", 32'({busy, rsp_valid_0, rsp_result_0, rsp_zero_0, rsp_err_0}), 32'b1_1_1000_0_0);
    @(negedge clk); check("t1_T3_idle", 32'({busy, rsp_valid_0}), 32'b00);

    // Both valid from reset: grant order 0,1,0.
    @(posedge clk); #1; rst_n = 0;
    req_valid_0 = 1; req_a_0 = 4'd9; req_b_0 = 4'd8; req_op_0 = 3'b010;
    req_valid_1 = 1; req_a_1 = 4'd5; req_b_1 = 4'd5; req_op_1 = 3'b110;
    @(posedge clk); #1; rst_n = 1;
    ngrant = 0; got0 = 0; got1 = 0; dropped = 0; r0 = '0; r1 = '0;
    for (int i = 0; i < 40 && !(ngrant >= 3 && got0 && got1); i++) begin
      @(negedge clk);
      if (req_ready_0 && req_valid_0 && ngrant < 3) begin order[ngrant] = 0; ngrant++; end
      if (req_ready_1 && req_valid_1 && ngrant < 3) begin order[ngrant] = 1; ngrant++; end
      if (rsp_valid_0 && !got0) begin r0 = {rsp_result_0, rsp_zero_0, rsp_carry_0}; got0 = 1; end
      if (rsp_valid_1 && !got1) begin r1 = {rsp_result_1, rsp_zero_1, rsp_carry_1}; got1 = 1; end
      if (ngrant == 3 && !dropped) begin
        @(posedge clk); #1; req_valid_0 = 0; req_valid_1 = 0; dropped = 1;
      end
    end
    check("t2_grant_count", 32'(ngrant), 32'd3);
    check("t2_grant_order", 32'({order[0][1:0], order[1][1:0], order[2][1:0]}), 32'b00_01_00);
    check("t2_rsp0_add", 32'({got0, r0}), 32'b1_0001_0_1);
    check("t2_rsp1_sub", 32'({got1, r1}), 32'b1_0000_1_0);
    drain();

    // EXEC_CYCLES=4 instance: OR 3|4 on req1.
    @(posedge clk); #1;
    x_req_valid_1 = 1; x_req_a_1 = 4'd3; x_req_b_1 = 4'd4; x_req_op_1 = 3'b001;
    @(negedge clk); check("t3_ready_T", 32'(x_req_ready_1), 32'd1);
    @(posedge clk); #1; x_req_valid_1 = 0; x_req_a_1 = 4'hF; x_req_op_1 = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("t3_exec_hold", 32'({x_alu_a, x_alu_b, x_alu_op, x_rsp_valid_1, x_busy}), 32'b0011_0100_001_0_1);
    end
    @(negedge clk); check("t3_rsp_T5", 32'({x_rsp_valid_1, x_rsp_result_1}), 32'b1_0111);

    // Illegal op 101, then a legal PIB clears err.
    @(posedge clk); #1;
    req_valid_0 = 1; req_a_0 = 4'd3; req_b_0 = 4'd3; req_op_0 = 3'b101;
    @(negedge clk); check("t4_ready_T", 32'(req_ready_0), 32'd1);
    @(posedge clk); #1; req_valid_0 = 0;
    @(negedge clk);
    check("t4_err_T1", 32'({rsp_valid_0, rsp_result_0, rsp_zero_0, rsp_carry_0, rsp_err_0}), 32'b1_0000_0_0_1);
    @(posedge clk); #1;
    req_valid_0 = 1; req_a_0 = 4'd2; req_b_0 = 4'd5; req_op_0 = 3'b111;
    @(negedge clk); check("t4_legal_ready", 32'(req_ready_0), 32'd1);
    @(posedge clk); #1; req_valid_0 = 0;
    @(negedge clk);
    @(negedge clk);
    check("t4_err_cleared", 32'({rsp_valid_0, rsp_result_0, rsp_zero_0, rsp_carry_0, rsp_err_0}), 32'b1_0101_0_0_0);
    drain();

    // Backpressure: rsp_ready_0 low for 10 cycles while req1 waits.
    @(posedge clk); #1;
    rsp_ready_0 = 0; req_valid_0 = 1; req_a_0 = 4'hF; req_b_0 = 4'h6; req_op_0 = 3'b000;
    @(negedge clk); check("t5_ready_T", 32'(req_ready_0), 32'd1);
    @(posedge clk); #1; req_valid_0 = 0;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid_1 = 1; req_a_1 = 4'd1; req_b_1 = 4'd2; req_op_1 = 3'b010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold", 32'({rsp_valid_0, rsp_result_0, req_ready_1}), 32'b1_0110_0);
    end
    @(posedge clk); #1; rsp_ready_0 = 1;
    @(negedge clk); check("t5_release", 32'({rsp_valid_0, req_ready_1}), 32'b10);
    @(negedge clk); check("t5_grant1_next", 32'({rsp_valid_0, req_ready_1}), 32'b01);
    @(posedge clk); #1; req_valid_1 = 0;
    drain();

    // Reset mid-EXEC on both instances after a req0 accept.
    @(posedge clk); #1;
    req_valid_0 = 1; req_a_0 = 4'd7; req_b_0 = 4'd1; req_op_0 = 3'b010;
    x_req_valid_0 = 1; x_req_a_0 = 4'd1; x_req_b_0 = 4'd1; x_req_op_0 = 3'b010;
    @(negedge clk); check("t6_ready_both", 32'({req_ready_0, x_req_ready_0}), 32'b11);
    @(posedge clk); #1; req_valid_0 = 0; x_req_valid_0 = 0;
    #2 rst_n = 0;
    #1;
    check("t6_reset_now", 32'(all_out), 32'd0);
    check("t6_reset_now4", 32'({x_busy, x_rsp_valid_0, x_rsp_valid_1, x_alu_a, x_alu_b, x_alu_op}), 32'd0);
    @(posedge clk); @(posedge clk); #1; rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_stale_rsp", 32'({rsp_valid_0, rsp_valid_1, busy, x_rsp_valid_0, x_rsp_valid_1, x_busy}), 32'd0);
    end
    @(posedge clk); #1;
    req_valid_0 = 1; req_valid_1 = 1;
    @(negedge clk); check("t6_ptr_zero", 32'({req_ready_0, req_ready_1}), 32'b10);
    @(posedge clk); #1; req_valid_0 = 0; req_valid_1 = 0;
    @(negedge clk);
    @(negedge clk); check("t6_after_reset_rsp", 32'({rsp_valid_0, rsp_result_0, rsp_err_0}), 32'b1_1000_0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
